// File: rtl/prio_encoder_disp_pkg.sv
// Shared display helpers for prio_encoder_disp: hex-to-7-segment table and
// blank codes for both segment polarities.
package prio_encoder_disp_pkg;

    localparam logic [7:0] SEG_BLANK_AH = 8'h00;
    localparam logic [7:0] SEG_BLANK_AL = 8'hFF;

    // Active-high segment pattern, bit order {dp,g,f,e,d,c,b,a}; dp never lit.
    function automatic logic [7:0] hex2seg(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

    function automatic logic [7:0] seg_drive(input logic [7:0] seg_ah, input logic active_low);
        return active_low ? ~seg_ah : seg_ah;
    endfunction

    function automatic logic [7:0] seg_blank(input logic active_low);
        return active_low ? SEG_BLANK_AL : SEG_BLANK_AH;
    endfunction

endpackage

// File: rtl/prio_encoder_disp_sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a stable-count debouncer.
// DEB_CYCLES = 0 passes the synchroniser output straight through.
module sw_debounce #(
    parameter int unsigned DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic stable_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            assign stable_o = sync2_q;
        end else begin : g_deb
            localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_q;
            logic             stable_d;

            // The edge that completes DEB_CYCLES differing cycles accepts the
            // new value; the counter therefore tops out at DEB_CYCLES-1.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (sync2_q != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable_o = stable_q;
        end
    endgenerate

endmodule

// File: rtl/prio_encoder_disp.sv
// Debounced N-input priority encoder with registered index, valid, change
// pulse and a two-digit hex 7-segment readout of the index.
module prio_encoder_disp
    import prio_encoder_disp_pkg::*;
#(
    parameter int unsigned N              = 8,
    parameter int unsigned DEB_CYCLES     = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    localparam int unsigned W             = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N:0]   sw,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         changed,
    output logic [7:0]   seg0,
    output logic [7:0]   seg1
);

    logic [N:0]   sw_stable;

    logic [W-1:0] y_d;
    logic         valid_d;
    logic [7:0]   y_ext;
    logic [7:0]   seg0_d;
    logic [7:0]   seg1_d;

    logic [W-1:0] y_q;
    logic         valid_q;
    logic [7:0]   seg0_q;
    logic [7:0]   seg1_q;
    logic [W:0]   prev_q;
    logic         changed_q;

    // Bit N is the encoder enable; it is filtered exactly like the requests.
    generate
        for (genvar i = 0; i <= N; i++) begin : g_sw
            sw_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk     (clk),
                .rst     (rst),
                .async_i (sw[i]),
                .stable_o(sw_stable[i])
            );
        end
    endgenerate

    always_comb begin
        y_d     = '0;
        valid_d = sw_stable[N] && (|sw_stable[N-1:0]);
        for (int i = 0; i < N; i++) begin
            if (sw_stable[i]) begin
                y_d = W'(i);
            end
        end
        if (!valid_d) begin
            y_d = '0;
        end
    end

    // Display is decoded from next-state so it lands on the same edge as y.
    always_comb begin
        y_ext  = 8'(y_d);
        seg0_d = seg_blank(SEG_ACTIVE_LOW);
        seg1_d = seg_blank(SEG_ACTIVE_LOW);
        if (valid_d) begin
            seg0_d = seg_drive(hex2seg(y_ext[3:0]), SEG_ACTIVE_LOW);
            if (W > 4) begin
                seg1_d = seg_drive(hex2seg(y_ext[7:4]), SEG_ACTIVE_LOW);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            valid_q   <= 1'b0;
            seg0_q    <= seg_blank(SEG_ACTIVE_LOW);
            seg1_q    <= seg_blank(SEG_ACTIVE_LOW);
            prev_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            valid_q   <= valid_d;
            seg0_q    <= seg0_d;
            seg1_q    <= seg1_d;
            // Compare against the previously registered pair, so the pulse
            // trails the y/valid update by one edge.
            prev_q    <= {valid_q, y_q};
            changed_q <= ({valid_q, y_q} != prev_q);
        end
    end

    assign y       = y_q;
    assign valid   = valid_q;
    assign changed = changed_q;
    assign seg0    = seg0_q;
    assign seg1    = seg1_q;

endmodule

// File: tb/tb_prio_encoder_disp.sv
// Scoreboard bench for prio_encoder_disp: an N=8/DEB=4 instance and an
// N=32/DEB=0 instance, expectations queued against absolute edge counts.
module tb_prio_encoder_disp;

    typedef struct {
        int         cyc;
        int         dut;
        string      tag;
        logic [5:0] y;
        logic       v;
        logic       ch;
        logic [7:0] s0;
        logic [7:0] s1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  sw_a;
    logic [2:0]  y_a;
    logic        valid_a, changed_a;
    logic [7:0]  seg0_a, seg1_a;
    logic [32:0] sw_b;
    logic [4:0]  y_b;
    logic        valid_b, changed_b;
    logic [7:0]  seg0_b, seg1_b;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];

    prio_encoder_disp #(.N(8), .DEB_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .sw(sw_a), .y(y_a), .valid(valid_a),
        .changed(changed_a), .seg0(seg0_a), .seg1(seg1_a)
    );

    prio_encoder_disp #(.N(32), .DEB_CYCLES(0), .SEG_ACTIVE_LOW(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .sw(sw_b), .y(y_b), .valid(valid_b),
        .changed(changed_b), .seg0(seg0_b), .seg1(seg1_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int dut, input string tag, input int dly,
                        input logic [5:0] y, input logic v, input logic ch,
                        input logic [7:0] s0, input logic [7:0] s1);
        exp_t e;
        e.cyc = cyc + dly;
        e.dut = dut;
        e.tag = tag;
        e.y   = y;
        e.v   = v;
        e.ch  = ch;
        e.s0  = s0;
        e.s1  = s1;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                e = sbq[i];
                if (e.dut == 0) begin
                    chk({e.tag, "_y"},  32'(y_a),       32'(e.y));
                    chk({e.tag, "_v"},  32'(valid_a),   32'(e.v));
                    chk({e.tag, "_ch"}, 32'(changed_a), 32'(e.ch));
                    chk({e.tag, "_s0"}, 32'(seg0_a),    32'(e.s0));
                    chk({e.tag, "_s1"}, 32'(seg1_a),    32'(e.s1));
                end else begin
                    chk({e.tag, "_y"},  32'(y_b),       32'(e.y));
                    chk({e.tag, "_v"},  32'(valid_b),   32'(e.v));
                    chk({e.tag, "_ch"}, 32'(changed_b), 32'(e.ch));
                    chk({e.tag, "_s0"}, 32'(seg0_b),    32'(e.s0));
                    chk({e.tag, "_s1"}, 32'(seg1_b),    32'(e.s1));
                end
                sbq.delete(i);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        sw_a = '0;
        sw_b = '0;
        step(2);
        rst = 1'b0;
        push(0, "a_rst",   0, 0, 0, 0, 8'hFF, 8'hFF);
        push(1, "b_rst",   0, 0, 0, 0, 8'hFF, 8'hFF);
        push(0, "a_idle",  3, 0, 0, 0, 8'hFF, 8'hFF);
        push(1, "b_idle",  3, 0, 0, 0, 8'hFF, 8'hFF);
        step(4);

        // Requests 7 and 2 with enable: 7 wins after 2+4+1 edges
        sw_a = 9'b1_1000_0100;
        push(0, "a_lat_pre", 6, 0, 0, 0, 8'hFF, 8'hFF);
        push(0, "a_lat_y",   7, 7, 1, 0, 8'hF8, 8'hFF);
        push(0, "a_chg",     8, 7, 1, 1, 8'hF8, 8'hFF);
        push(0, "a_chg_end", 9, 7, 1, 0, 8'hF8, 8'hFF);
        step(12);

        // 3-cycle glitch low on sw[7] must be filtered out
        for (int d = 1; d <= 12; d++) push(0, "a_glitch", d, 7, 1, 0, 8'hF8, 8'hFF);
        sw_a[7] = 1'b0;
        step(3);
        sw_a[7] = 1'b1;
        step(12);

        // Permanent drop of sw[7]: falls back to index 2
        sw_a = 9'b1_0000_0100;
        push(0, "a_fall_pre", 6, 7, 1, 0, 8'hF8, 8'hFF);
        push(0, "a_fall_y",   7, 2, 1, 0, 8'hA4, 8'hFF);
        push(0, "a_fall_chg", 8, 2, 1, 1, 8'hA4, 8'hFF);
        step(10);

        sw_a = 9'b1_1000_0100;
        push(0, "a_back_y",   7, 7, 1, 0, 8'hF8, 8'hFF);
        push(0, "a_back_chg", 8, 7, 1, 1, 8'hF8, 8'hFF);
        step(10);

        // Enable dropped: outputs blank after full latency, one change pulse
        sw_a = 9'b0_1000_0100;
        push(0, "a_en_pre",  6, 7, 1, 0, 8'hF8, 8'hFF);
        push(0, "a_en_off",  7, 0, 0, 0, 8'hFF, 8'hFF);
        push(0, "a_en_chg",  8, 0, 0, 1, 8'hFF, 8'hFF);
        push(0, "a_en_end",  9, 0, 0, 0, 8'hFF, 8'hFF);
        step(10);

        // Reset in the middle of debouncing sw[3]: full latency restarts
        sw_a = 9'b1_0000_1000;
        step(2);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        push(0, "a_mid_rst", 0, 0, 0, 0, 8'hFF, 8'hFF);
        push(0, "a_mid_pre", 6, 0, 0, 0, 8'hFF, 8'hFF);
        push(0, "a_mid_y",   7, 3, 1, 0, 8'hB0, 8'hFF);
        push(0, "a_mid_chg", 8, 3, 1, 1, 8'hB0, 8'hFF);
        step(10);

        // Wide instance, no debounce: index 26 shows "1A"
        sw_b = 33'h1_0400_0000;
        push(1, "b26_pre", 2, 0,  0, 0, 8'hFF, 8'hFF);
        push(1, "b26_y",   3, 26, 1, 0, 8'h88, 8'hF9);
        push(1, "b26_chg", 4, 26, 1, 1, 8'h88, 8'hF9);
        step(6);

        sw_b[31] = 1'b1;
        push(1, "b31_y",   3, 31, 1, 0, 8'h8E, 8'hF9);
        push(1, "b31_chg", 4, 31, 1, 1, 8'h8E, 8'hF9);
        step(6);

        sw_b = 33'h1_0000_0000;
        push(1, "b_none_y",   3, 0, 0, 0, 8'hFF, 8'hFF);
        push(1, "b_none_chg", 4, 0, 0, 1, 8'hFF, 8'hFF);
        step(6);

        // Index 0 valid: both digits show 0
        sw_b = 33'h1_0000_0001;
        push(1, "b0_y",   3, 0, 1, 0, 8'hC0, 8'hC0);
        push(1, "b0_chg", 4, 0, 1, 1, 8'hC0, 8'hC0);
        push(1, "b0_end", 5, 0, 1, 0, 8'hC0, 8'hC0);
        step(6);

        for (int i = 0; i < 50 && sbq.size() > 0; i++) step(1);
        chk("sb_drain", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
